// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bundle: instruction-memory read port, decode-side valid/ready
// handshake and the redirect/halt controls.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_data;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fifo_count,
    input  imem_ack, imem_data, instr_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, fifo_count,
    output imem_ack, imem_data, instr_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// SIC-4 fetch stage: owns the fetch PC, issues req/ack reads to instruction
// memory and buffers {pc, word} pairs in a prefetch FIFO for decode.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);
  localparam int               PTR_W = $clog2(DEPTH);
  localparam int               CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              push;
  logic              pop;
  logic              launch;
  logic              head_valid;

  // Launch looks at post-edge occupancy so every issued read owns a free slot.
  always_comb begin
    head_valid = (count != '0);
    pop        = head_valid && bus.instr_ready;
    push       = (state == REQ) && bus.imem_ack && !bus.redirect;
    pc_inc     = fetch_pc + ADDR_W'(1);
    count_next = count;
    if (bus.redirect) begin
      count_next = '0;
    end else begin
      count_next = count + CNT_W'(push) - CNT_W'(pop);
    end
    launch = !bus.halt && !bus.redirect && (count_next < FULL);
  end

  // Storage carries no reset; occupancy and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      data_mem[wr_ptr] <= bus.imem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req      <= 1'b0;
      addr     <= RESET_PC;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      count <= count_next;
      if (bus.redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case (state)
        IDLE: begin
          if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
          end else if (launch) begin
            state <= REQ;
            req   <= 1'b1;
            addr  <= fetch_pc;
          end
        end
        REQ: begin
          if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            if (bus.imem_ack) begin
              state <= IDLE;
              req   <= 1'b0;
            end else begin
              state <= DISCARD;
            end
          end else if (bus.imem_ack) begin
            fetch_pc <= pc_inc;
            if (launch) begin
              addr <= pc_inc;
            end else begin
              state <= IDLE;
              req   <= 1'b0;
            end
          end
        end
        DISCARD: begin
          // The stale read must still complete before a new address can go out.
          if (bus.redirect) fetch_pc <= bus.redirect_pc;
          if (bus.imem_ack) begin
            state <= IDLE;
            req   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = addr;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_valid ? data_mem[rd_ptr] : '0;
  assign bus.instr_pc    = head_valid ? pc_mem[rd_ptr] : '0;
  assign bus.fifo_count  = count;
endmodule
